// File: rtl/melody_pkg.sv
// Shared types, ROM field offsets, note pitch constants and the duration
// decoder for the table-driven melody sequencer.
package melody_pkg;

  // Sequencer control states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_GAP    = 3'd3,
    ST_PAUSED = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Note length codes stored in the ROM Dur field.
  typedef enum logic [1:0] {
    DUR_HALF = 2'b00,
    DUR_ONE  = 2'b01,
    DUR_TWO  = 2'b10,
    DUR_FOUR = 2'b11
  } dur_t;

  // ROM word layout, as offsets above the OV_W-bit overflow field:
  // [OV_W+2] End, [OV_W+1:OV_W] Dur, [OV_W-1:0] Ov_f.
  localparam int ROM_END_OFS    = 2;
  localparam int ROM_DUR_HI_OFS = 1;
  localparam int ROM_DUR_LO_OFS = 0;

  // Tone-generator overflow values for the usual pitches (0 = rest).
  localparam logic [27:0] OV_REST = 28'd0;
  localparam logic [27:0] OV_RE3  = 28'd27244;
  localparam logic [27:0] OV_MI3  = 28'd24279;
  localparam logic [27:0] OV_FA3  = 28'd22922;
  localparam logic [27:0] OV_SOL3 = 28'd20408;
  localparam logic [27:0] OV_LA3  = 28'd18181;
  localparam logic [27:0] OV_SIB3 = 28'd17167;
  localparam logic [27:0] OV_DO4  = 28'd15296;
  localparam logic [27:0] OV_RE4  = 28'd13617;
  localparam logic [27:0] OV_MI4  = 28'd12139;
  localparam logic [27:0] OV_FA4  = 28'd11453;

  // Total note length in clock cycles (PLAY plus GAP) for a duration code.
  function automatic logic [31:0] dur_cycles(input dur_t code, input logic [31:0] beat_cyc);
    logic [31:0] cyc;
    case (code)
      DUR_HALF: cyc = beat_cyc >> 1;
      DUR_ONE:  cyc = beat_cyc;
      DUR_TWO:  cyc = beat_cyc << 1;
      DUR_FOUR: cyc = beat_cyc << 2;
      default:  cyc = beat_cyc;
    endcase
    return cyc;
  endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter that times the PLAY and GAP phases of a note.
// A load wins over counting; counting only happens while enabled, so the
// count freezes while the sequencer is paused. o_last flags the final cycle
// of the loaded interval (count == 1), i.e. a load of N lasts N cycles.
module note_timer #(
  parameter int W = 7
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_last
);

  logic [W-1:0] r_count;

  // Count register: synchronous clear, load, or decrement (never below zero).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= {W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != {W{1'b0}})) begin
      r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_last = (r_count == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/melody_sequencer_ctrl.sv
// Table-driven melody sequencer. Walks a song stored in an external ROM,
// drives each note's tone overflow for (D - GAP_CYC) cycles followed by a
// silent GAP_CYC articulation gap, and handles play/pause/stop/loop control.
// The next ROM word is prefetched at the start of each gap so consecutive
// notes follow each other with no dead cycle.
module melody_sequencer_ctrl
  import melody_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int OV_W     = 28,
  parameter int BEAT_CYC = 30000000,
  parameter int GAP_CYC  = 2500000
) (
  input  logic              Clk_in,
  input  logic              Rst_in,
  input  logic              Play_in,
  input  logic              Pause_in,
  input  logic              Stop_in,
  input  logic              Loop_in,
  output logic [ADDR_W-1:0] Rom_addr,
  input  logic [OV_W+2:0]   Rom_data,
  output logic [OV_W-1:0]   Freq_out,
  output logic              Note_strobe,
  output logic              Busy,
  output logic              Done
);

  localparam int          TMR_W       = $clog2(4 * BEAT_CYC + 1);
  localparam logic [31:0] BEAT_CYC_32 = 32'(BEAT_CYC);
  localparam logic [31:0] GAP_CYC_32  = 32'(GAP_CYC);
  localparam logic [TMR_W-1:0] GAP_LEN = TMR_W'(GAP_CYC);

  // Registered state and outputs.
  state_t            r_state;
  state_t            r_ret;
  logic [ADDR_W-1:0] r_addr;
  logic [OV_W-1:0]   r_freq;
  logic              r_strobe;
  logic              r_busy;
  logic              r_done;
  logic [OV_W-1:0]   r_ov;
  logic              r_end;

  // ROM word fields.
  logic              w_rom_end;
  logic [1:0]        w_rom_dur;
  logic [OV_W-1:0]   w_rom_ov;
  logic [31:0]       w_dur_cyc;
  logic [TMR_W-1:0]  w_play_len;

  // Next-state / control decisions.
  state_t            w_next;
  state_t            w_ret_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [OV_W-1:0]   w_freq_nxt;
  logic              w_strobe_nxt;
  logic              w_latch;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_tmr_en;
  logic              w_tmr_last;

  assign w_rom_end  = Rom_data[OV_W + ROM_END_OFS];
  assign w_rom_dur  = Rom_data[OV_W + ROM_DUR_HI_OFS : OV_W + ROM_DUR_LO_OFS];
  assign w_rom_ov   = Rom_data[OV_W-1:0];
  assign w_dur_cyc  = dur_cycles(dur_t'(w_rom_dur), BEAT_CYC_32);
  // The audible part of a note is its full length minus the trailing gap.
  assign w_play_len = TMR_W'(w_dur_cyc - GAP_CYC_32);

  note_timer #(
    .W (TMR_W)
  ) u_note_timer (
    .i_clk      (Clk_in),
    .i_rst      (Rst_in),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_last     (w_tmr_last)
  );

  // Next-state, ROM address, timer control and next output values.
  always_comb begin
    w_next       = r_state;
    w_ret_nxt    = r_ret;
    w_addr_nxt   = r_addr;
    w_strobe_nxt = 1'b0;
    w_latch      = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = {TMR_W{1'b0}};
    w_tmr_en     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_addr_nxt = {ADDR_W{1'b0}};
        if (Play_in && !Stop_in) begin
          w_next = ST_FETCH;
        end else begin
          w_next = ST_IDLE;
        end
      end

      // Entry 0 is on the ROM bus by now; start the first note.
      ST_FETCH: begin
        w_latch      = 1'b1;
        w_tmr_load   = 1'b1;
        w_tmr_val    = w_play_len;
        w_strobe_nxt = 1'b1;
        w_next       = ST_PLAY;
      end

      // The last PLAY cycle always reaches GAP; a pause is honoured there.
      ST_PLAY: begin
        if (w_tmr_last) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = GAP_LEN;
          w_addr_nxt = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          w_next     = ST_GAP;
        end else if (Pause_in) begin
          w_tmr_en  = 1'b1;
          w_ret_nxt = ST_PLAY;
          w_next    = ST_PAUSED;
        end else begin
          w_tmr_en = 1'b1;
        end
      end

      // The End/Loop decision on the last GAP cycle takes precedence over pause.
      ST_GAP: begin
        if (w_tmr_last) begin
          if (!r_end) begin
            w_latch      = 1'b1;
            w_tmr_load   = 1'b1;
            w_tmr_val    = w_play_len;
            w_strobe_nxt = 1'b1;
            w_next       = ST_PLAY;
          end else if (Loop_in) begin
            w_addr_nxt = {ADDR_W{1'b0}};
            w_next     = ST_FETCH;
          end else begin
            w_next = ST_DONE;
          end
        end else if (Pause_in) begin
          w_tmr_en  = 1'b1;
          w_ret_nxt = ST_GAP;
          w_next    = ST_PAUSED;
        end else begin
          w_tmr_en = 1'b1;
        end
      end

      // Timer and address hold; resume exactly where the note left off.
      ST_PAUSED: begin
        if (!Pause_in) begin
          w_next = r_ret;
        end else begin
          w_next = ST_PAUSED;
        end
      end

      ST_DONE: begin
        w_next = ST_IDLE;
      end

      default: begin
        w_next     = ST_IDLE;
        w_addr_nxt = {ADDR_W{1'b0}};
      end
    endcase

    // Stop overrides every other decision, including a pending note start.
    if (Stop_in) begin
      w_next       = ST_IDLE;
      w_addr_nxt   = {ADDR_W{1'b0}};
      w_strobe_nxt = 1'b0;
      w_latch      = 1'b0;
      w_tmr_load   = 1'b1;
      w_tmr_val    = {TMR_W{1'b0}};
      w_tmr_en     = 1'b0;
    end else begin
      w_next = w_next;
    end

    // Tone is heard only in PLAY; a freshly latched entry is used immediately.
    if (w_next == ST_PLAY) begin
      if (w_latch) begin
        w_freq_nxt = w_rom_ov;
      end else begin
        w_freq_nxt = r_ov;
      end
    end else begin
      w_freq_nxt = {OV_W{1'b0}};
    end
  end

  // State, latched ROM entry and registered outputs.
  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      r_state  <= ST_IDLE;
      r_ret    <= ST_IDLE;
      r_addr   <= {ADDR_W{1'b0}};
      r_freq   <= {OV_W{1'b0}};
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ov     <= {OV_W{1'b0}};
      r_end    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_ret    <= w_ret_nxt;
      r_addr   <= w_addr_nxt;
      r_freq   <= w_freq_nxt;
      r_strobe <= w_strobe_nxt;
      r_busy   <= (w_next != ST_IDLE);
      r_done   <= (w_next == ST_DONE);
      if (w_latch) begin
        r_ov  <= w_rom_ov;
        r_end <= w_rom_end;
      end else begin
        r_ov  <= r_ov;
        r_end <= r_end;
      end
    end
  end

  assign Rom_addr    = r_addr;
  assign Freq_out    = r_freq;
  assign Note_strobe = r_strobe;
  assign Busy        = r_busy;
  assign Done        = r_done;

endmodule

// File: doc/melody_sequencer_ctrl.md
Name: melody_sequencer_ctrl

Overview:
- Table-driven note sequencer. It fetches note entries from an external synchronous song ROM.
- For each note it drives the tone-overflow value to the existing tone generator, times the note duration internally, and inserts a silent articulation gap between notes.
- Play/pause/stop/loop control comes from debounced user inputs.
- It replaces the hard-coded per-state note FSM. The sequence now lives in ROM, so new songs need no RTL change.

Parameters:
- ADDR_W, 6, song ROM address width (up to 64 entries).
- OV_W, 28, width of the tone overflow field and of Freq_out.
- BEAT_CYC, 30000000, clock cycles per beat (100 BPM at 50 MHz).
- GAP_CYC, 2500000, silent cycles at the end of every note. Legal range: 2 <= GAP_CYC < BEAT_CYC/2.

Ports:
- Clk_in  in  1  system clock, 50 MHz.
- Rst_in  in  1  synchronous reset, active-high.
- Play_in  in  1  level; starts playback from entry 0 when idle.
- Pause_in  in  1  level; freezes playback while high.
- Stop_in  in  1  level; aborts playback and returns to idle.
- Loop_in  in  1  sampled at song end; 1 restarts at entry 0.
- Rom_addr  out  ADDR_W  registered ROM address.
- Rom_data  in  OV_W+3  ROM word, valid 1 cycle after Rom_addr changes. Fields: [OV_W+2] End, [OV_W+1:OV_W] Dur, [OV_W-1:0] Ov_f.
- Freq_out  out  OV_W  tone overflow to the tone generator; 0 = silence.
- Note_strobe  out  1  1-cycle pulse when a note's PLAY phase begins.
- Busy  out  1  1 in every state except IDLE.
- Done  out  1  1-cycle pulse when a song ends without looping.

Behaviour:
- Reset values:
  - state IDLE; Rom_addr 0; Freq_out 0; Note_strobe 0; Busy 0; Done 0.
  - timer 0; latched entry cleared.
- Duration decode (cycles D):
  - Dur 00 = BEAT_CYC/2, 01 = BEAT_CYC, 10 = 2*BEAT_CYC, 11 = 4*BEAT_CYC.
  - Timer width = clog2(4*BEAT_CYC+1).
- Ov_f = 0 is a rest: same timing, Freq_out 0 throughout.
- IDLE:
  - Rom_addr = 0, Freq_out = 0.
  - Play_in=1 and Stop_in=0 -> FETCH.
- FETCH: exactly 1 wait cycle. Then latch Rom_data, load timer with D-GAP_CYC, pulse Note_strobe, go to PLAY.
- PLAY:
  - Freq_out = latched Ov_f; timer decrements each cycle.
  - On the last cycle: load timer with GAP_CYC, Rom_addr += 1 (prefetch), go to GAP.
- GAP:
  - Freq_out = 0; timer decrements.
  - On the last cycle, if latched End=0: latch Rom_data (already valid), load D-GAP_CYC, pulse Note_strobe, go to PLAY. No dead cycle between notes.
  - If End=1 and Loop_in=1: Rom_addr = 0, go to FETCH.
  - If End=1 and Loop_in=0: go to DONE.
- DONE: pulse Done for 1 cycle, then IDLE.
- Note period: exactly D cycles per note; the first note after Play or a loop restart adds 1 FETCH cycle.
- Rom_addr wraps from 2^ADDR_W-1 to 0 when no End flag is present; this is not an error.
- PAUSED:
  - Entered from PLAY or GAP when Pause_in=1. Saves the return state; timer and Rom_addr hold.
  - Freq_out = 0, Busy = 1.
  - On Pause_in=0, resume the saved state with the remaining count.
  - Pause in FETCH takes effect after the FETCH cycle.
- Stop_in=1 in any state:
  - Next cycle: IDLE, Rom_addr 0, Freq_out 0.
  - No Done pulse; any pending Note_strobe is suppressed.
  - Stop has priority over Pause, Play, and the End/Loop decision.
- Play_in while Busy=1: ignored. Play_in held high in IDLE after Done or Stop: restarts playback (level semantics).
- Rst_in mid-operation: same effect as Stop, plus all registers return to reset values in the next cycle.
- Simultaneous events on the same cycle:
  - Pause_in and the last PLAY cycle: the transition to GAP completes first, then PAUSED on the next cycle.
  - Pause_in and an End decision: DONE or FETCH wins; Pause is then applied only if still Busy.

Decomposition:
- melody_pkg holds:
  - state enum (IDLE, FETCH, PLAY, GAP, PAUSED, DONE) and duration-code enum;
  - ROM field bit positions;
  - note overflow constants Re3..Fa4 (27244, 24279, 22922, 20408, 18181, 17167, 15296, 13617, 12139, 11453);
  - duration decode function.
- One sub-module, note_timer: loadable down-counter with hold enable and a last-cycle flag.

Test Plan:
All scenarios use BEAT_CYC=20 and GAP_CYC=4.
1. ROM {End0, Dur01, 22922}, {End1, Dur00, 0}; pulse Play -> Note_strobe 2 cycles later; Freq_out 22922 for 16 cycles, 0 for 4; rest note 0 for 10; Done pulse; Busy 0.
2. Dur11 note, Pause_in high for 7 cycles at PLAY cycle 10 -> Freq_out 0 during pause; total PLAY cycles at 11629 still 76; GAP 4.
3. Stop_in mid-PLAY of note 2 -> next cycle Freq_out 0, Busy 0, Rom_addr 0, Done never asserted.
4. Loop_in=1, 3-entry song -> after the End note's GAP, Rom_addr 0, 1 FETCH cycle, Note_strobe with entry 0; verify 3 full loops.
5. Play and Stop asserted in the same IDLE cycle -> remains IDLE. Play pulsed while Busy -> no restart, Rom_addr sequence unchanged.
6. Rst_in mid-GAP -> all outputs at reset values next cycle. Back-to-back notes -> Note_strobe spacing exactly D cycles (10/20/40/80).
